// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation sequencer.
//   state_t : sequencer states
//   SEL_*   : shift-direction select encodings driven to the PE array
//   MV_W    : width of candidate coordinates and buffer indices
package me_pkg;

  localparam int MV_W = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_CPR = 3'd1,
    LOAD_SPR = 3'd2,
    SCAN     = 3'd3,
    HSHIFT   = 3'd4,
    DRAIN    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_DOWN = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_LEFT = 2'b10;

endpackage

// File: rtl/me_align_pipe.sv
// Delay line that carries {valid, y, x} of each candidate alongside the SAD
// pipeline, so the comparator sees the coordinates that belong to the SAD
// it is currently evaluating.
//   clk, rst_n        : clock, asynchronous active-low clear
//   cand_vld/y/x      : candidate issued this cycle
//   cmp_vld/y/x       : the same candidate, STAGES cycles later
module me_align_pipe #(
  parameter int STAGES = 2,
  parameter int DATA_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cand_vld,
  input  logic [DATA_W-1:0] cand_y,
  input  logic [DATA_W-1:0] cand_x,
  output logic              cmp_vld,
  output logic [DATA_W-1:0] cmp_y,
  output logic [DATA_W-1:0] cmp_x
);

  logic [STAGES-1:0]             vld_p;
  logic [STAGES-1:0][DATA_W-1:0] y_p;
  logic [STAGES-1:0][DATA_W-1:0] x_p;

  // Stage boundary: every stage shifts each cycle; reset flushes the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
      y_p   <= '0;
      x_p   <= '0;
    end else begin
      vld_p[0] <= cand_vld;
      y_p[0]   <= cand_y;
      x_p[0]   <= cand_x;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
        y_p[i]   <= y_p[i-1];
        x_p[i]   <= x_p[i-1];
      end
    end
  end

  assign cmp_vld = vld_p[STAGES-1];
  assign cmp_y   = y_p[STAGES-1];
  assign cmp_x   = x_p[STAGES-1];

endmodule

// File: rtl/control_me.sv
// Sequencer for one full-search block match: loads the current macroblock
// (CPR), loads the first MACRO_DIM search columns (SPR), then snakes through
// all N x N candidate offsets (down column 0, shift left, up column 1, ...),
// issuing one candidate per cycle and strobing the SAD comparator SUM_LAT
// cycles later.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start / ready       : request accepted only while ready (IDLE)
//   done                : one-cycle pulse after the last comparison
//   en_cpr, en_spr, sel : PE register enables and shift direction
//   cpr_rd_col          : current-block column read index
//   spr_rd_row/col      : search-window row / column read index
//   reset_sum           : clears the comparator minimum on accept
//   comp_en, addr, amt  : comparator strobe with candidate y / x
module control_me
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SUM_LAT    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            ready,
  output logic            done,
  output logic            en_cpr,
  output logic            en_spr,
  output logic [1:0]      sel,
  output logic [MV_W-1:0] cpr_rd_col,
  output logic [MV_W-1:0] spr_rd_row,
  output logic [MV_W-1:0] spr_rd_col,
  output logic            reset_sum,
  output logic            comp_en,
  output logic [MV_W-1:0] addr,
  output logic [MV_W-1:0] amt
);

  localparam logic [MV_W-1:0] LAST_POS   = MV_W'(SEARCH_DIM - MACRO_DIM);
  localparam logic [MV_W-1:0] MB_DIM     = MV_W'(MACRO_DIM);
  localparam logic [MV_W-1:0] LOAD_LAST  = MV_W'(MACRO_DIM - 1);
  localparam logic [MV_W-1:0] DRAIN_LAST = MV_W'(SUM_LAT);
  localparam logic [MV_W-1:0] ONE        = MV_W'(1);

  state_t          state;
  logic [MV_W-1:0] cnt;
  logic [MV_W-1:0] x;
  logic [MV_W-1:0] y;
  logic            dir_up;
  logic            col_end;
  logic            cand_valid;

  // The last row of a column depends on the snake direction.
  assign col_end    = dir_up ? (y == '0) : (y == LAST_POS);
  assign cand_valid = (state == SCAN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      x      <= '0;
      y      <= '0;
      dir_up <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_CPR;
            cnt   <= '0;
          end
        end
        LOAD_CPR: begin
          if (cnt == LOAD_LAST) begin
            state <= LOAD_SPR;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        LOAD_SPR: begin
          if (cnt == LOAD_LAST) begin
            state  <= SCAN;
            cnt    <= '0;
            x      <= '0;
            y      <= '0;
            dir_up <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        SCAN: begin
          if (!col_end) begin
            y <= dir_up ? (y - ONE) : (y + ONE);
          end else if (x == LAST_POS) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            state <= HSHIFT;
          end
        end
        HSHIFT: begin
          x      <= x + ONE;
          dir_up <= ~dir_up;
          state  <= SCAN;
        end
        DRAIN: begin
          // SUM_LAT cycles flush the SAD pipe; the extra final cycle carries done.
          if (cnt == DRAIN_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    ready      = (state == IDLE);
    reset_sum  = (state == IDLE) && start;
    done       = (state == DRAIN) && (cnt == DRAIN_LAST);
    en_cpr     = 1'b0;
    en_spr     = 1'b0;
    sel        = SEL_DOWN;
    cpr_rd_col = '0;
    spr_rd_row = '0;
    spr_rd_col = '0;
    unique case (state)
      LOAD_CPR: begin
        en_cpr     = 1'b1;
        cpr_rd_col = cnt;
      end
      LOAD_SPR: begin
        en_spr     = 1'b1;
        sel        = SEL_LEFT;
        spr_rd_col = cnt;
      end
      SCAN: begin
        // Shifting down pulls in the row just below the window; shifting up
        // pulls in the row just above it. Never issued on the column's last row.
        if (!col_end) begin
          en_spr     = 1'b1;
          sel        = dir_up ? SEL_UP : SEL_DOWN;
          spr_rd_row = dir_up ? (y - ONE) : (y + MB_DIM);
        end
      end
      HSHIFT: begin
        en_spr     = 1'b1;
        sel        = SEL_LEFT;
        spr_rd_col = x + MB_DIM;
      end
      default: ;
    endcase
  end

  me_align_pipe #(
    .STAGES(SUM_LAT),
    .DATA_W(MV_W)
  ) u_align (
    .clk     (clk),
    .rst_n   (rst_n),
    .cand_vld(cand_valid),
    .cand_y  (y),
    .cand_x  (x),
    .cmp_vld (comp_en),
    .cmp_y   (addr),
    .cmp_x   (amt)
  );

endmodule

// File: tb/tb_control_me.sv
// Directed bench for control_me: a 4/8 instance (N=5) and a degenerate
// 4/4 instance (N=1) share clock and reset.
module tb_control_me;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, start_b;

  logic       ready_a, done_a, en_cpr_a, en_spr_a, reset_sum_a, comp_en_a;
  logic [1:0] sel_a;
  logic [5:0] cpr_rd_col_a, spr_rd_row_a, spr_rd_col_a, addr_a, amt_a;
  logic       ready_b, done_b, en_cpr_b, en_spr_b, reset_sum_b, comp_en_b;
  logic [1:0] sel_b;
  logic [5:0] cpr_rd_col_b, spr_rd_row_b, spr_rd_col_b, addr_b, amt_b;

  always #5 clk = ~clk;

  control_me #(.MACRO_DIM(4), .SEARCH_DIM(8), .SUM_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ready(ready_a), .done(done_a),
    .en_cpr(en_cpr_a), .en_spr(en_spr_a), .sel(sel_a),
    .cpr_rd_col(cpr_rd_col_a), .spr_rd_row(spr_rd_row_a), .spr_rd_col(spr_rd_col_a),
    .reset_sum(reset_sum_a), .comp_en(comp_en_a), .addr(addr_a), .amt(amt_a)
  );

  control_me #(.MACRO_DIM(4), .SEARCH_DIM(4), .SUM_LAT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ready(ready_b), .done(done_b),
    .en_cpr(en_cpr_b), .en_spr(en_spr_b), .sel(sel_b),
    .cpr_rd_col(cpr_rd_col_b), .spr_rd_row(spr_rd_row_b), .spr_rd_col(spr_rd_col_b),
    .reset_sum(reset_sum_b), .comp_en(comp_en_b), .addr(addr_b), .amt(amt_b)
  );

  // Every output except ready, packed so one compare covers the reset state.
  logic [36:0] outs_a, outs_b;
  assign outs_a = {done_a, en_cpr_a, en_spr_a, sel_a, cpr_rd_col_a, spr_rd_row_a,
                   spr_rd_col_a, reset_sum_a, comp_en_a, addr_a, amt_a};
  assign outs_b = {done_b, en_cpr_b, en_spr_b, sel_b, cpr_rd_col_b, spr_rd_row_b,
                   spr_rd_col_b, reset_sum_b, comp_en_b, addr_b, amt_b};

  int checks   = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int ce_x[$];
  int ce_y[$];
  int done_k, rs_cnt, ce_cnt, left_cnt, clash_cnt, dn_cnt;

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check_val("rst_hold_ready_a", ready_a, 1);
    check_val("rst_hold_outs_a", outs_a, 0);
    check_val("rst_hold_ready_b", ready_b, 1);
    check_val("rst_hold_outs_b", outs_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_rel_ready_a", ready_a, 1);
    check_val("rst_rel_outs_a", outs_a, 0);

    // ---------------- full search, N=5 ----------------
    start_a = 1'b1;
    #1;
    check_val("accept_reset_sum", reset_sum_a, 1);
    check_val("accept_ready", ready_a, 1);
    @(posedge clk);
    #1 start_a = 1'b0;
    done_k = -1; rs_cnt = 0; left_cnt = 0; clash_cnt = 0; dn_cnt = 0;
    ce_x.delete(); ce_y.delete();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k < 4)
        check_val($sformatf("cpr_load_k%0d", k), {en_cpr_a, en_spr_a, cpr_rd_col_a}, {2'b10, 6'(k)});
      else if (k < 8)
        check_val($sformatf("spr_load_k%0d", k), {en_cpr_a, en_spr_a, sel_a, spr_rd_col_a},
                  {2'b01, 2'b10, 6'(k - 4)});
      else if (k < 12)
        check_val($sformatf("col0_row_k%0d", k), {en_spr_a, sel_a, spr_rd_row_a}, {1'b1, 2'b00, 6'(k - 4)});
      else if (k == 12)
        check_val("col0_last_no_shift", en_spr_a, 0);
      else if (k >= 14 && k < 18)
        check_val($sformatf("col1_row_k%0d", k), {en_spr_a, sel_a, spr_rd_row_a}, {1'b1, 2'b01, 6'(17 - k)});
      if (k == 13 || k == 19 || k == 25 || k == 31)
        check_val($sformatf("hshift_k%0d", k), {en_spr_a, sel_a, spr_rd_col_a},
                  {1'b1, 2'b10, 6'(4 + (k - 13) / 6)});
      if (k >= 8 && en_spr_a && sel_a == 2'b10) left_cnt++;
      if (comp_en_a) begin ce_x.push_back(int'(amt_a)); ce_y.push_back(int'(addr_a)); end
      if (reset_sum_a) rs_cnt++;
      if ((en_cpr_a && en_spr_a) || (done_a && ready_a)) clash_cnt++;
      if (done_a) begin dn_cnt++; if (done_k < 0) done_k = k; end
      if (k == 39) check_val("busy_before_done", ready_a, 0);
      if (k == 40) check_val("ready_after_done", ready_a, 1);
    end
    // done is captured by the consumer at the edge after its cycle starts
    check_val("done_latency", done_k + 1, 40);
    check_val("done_pulses", dn_cnt, 1);
    check_val("hshift_count", left_cnt, 4);
    check_val("no_extra_reset_sum", rs_cnt, 0);
    check_val("no_enable_clash", clash_cnt, 0);
    check_val("comp_en_count", ce_x.size(), 25);
    for (int i = 0; i < 25 && i < ce_x.size(); i++) begin
      int c, r;
      c = i / 5;
      r = (c % 2 == 0) ? (i % 5) : (4 - i % 5);
      check_val($sformatf("cand%0d_xy", i), {ce_x[i][15:0], ce_y[i][15:0]}, {16'(c), 16'(r)});
    end

    // ---------------- start held high while busy ----------------
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    done_k = -1; rs_cnt = 0; ce_cnt = 0;
    for (int k = 0; k < 46; k++) begin
      @(negedge clk);
      if (k < 40 && reset_sum_a) rs_cnt++;
      if (k < 40 && comp_en_a) ce_cnt++;
      if (done_a && done_k < 0) done_k = k;
      if (k == 40) check_val("busy_rearm_reset_sum", reset_sum_a, 1);
      if (k == 41) check_val("busy_second_run", {ready_a, en_cpr_a}, 2'b01);
    end
    check_val("busy_ignored_reset_sum", rs_cnt, 0);
    check_val("busy_single_search", ce_cnt, 25);
    check_val("busy_done_latency", done_k + 1, 40);
    start_a = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ready_a) break;
    end
    check_val("busy_second_finish", ready_a, 1);

    // ---------------- reset during SCAN at candidate (2,3) ----------------
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    repeat (24) @(negedge clk);
    check_val("midrst_at_cand_2_3", {en_spr_a, sel_a, spr_rd_row_a}, {1'b1, 2'b00, 6'd7});
    rst_n = 1'b0;
    #1;
    check_val("midrst_ready", ready_a, 1);
    check_val("midrst_outs", outs_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ce_cnt = 0; dn_cnt = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (comp_en_a) ce_cnt++;
      if (done_a) dn_cnt++;
    end
    check_val("midrst_no_comp_en", ce_cnt, 0);
    check_val("midrst_no_done", dn_cnt, 0);
    check_val("midrst_idle", ready_a, 1);

    // ---------------- degenerate N=1 ----------------
    start_b = 1'b1;
    #1;
    check_val("deg_reset_sum", reset_sum_b, 1);
    @(posedge clk);
    #1 start_b = 1'b0;
    done_k = -1; ce_cnt = 0; left_cnt = 0; dn_cnt = 0;
    ce_x.delete(); ce_y.delete();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (en_spr_b && sel_b == 2'b10) left_cnt++;
      if (comp_en_b) begin ce_cnt++; ce_x.push_back(int'(amt_b)); ce_y.push_back(int'(addr_b)); end
      if (done_b) begin dn_cnt++; if (done_k < 0) done_k = k; end
      if (k == 12) check_val("deg_ready_after_done", ready_b, 1);
    end
    check_val("deg_comp_en_count", ce_cnt, 1);
    if (ce_x.size() > 0)
      check_val("deg_cand_xy", {ce_x[0][15:0], ce_y[0][15:0]}, 32'd0);
    check_val("deg_left_shifts", left_cnt, 4);
    check_val("deg_done_latency", done_k + 1, 12);
    check_val("deg_done_pulses", dn_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
